// File: rtl/dc_fifo_pkg.sv
// Shared helpers for the dc_fifo_af_ae FIFO: depth derivation and the per-cycle operation type.
package dc_fifo_pkg;

  function automatic int unsigned dc_fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Pointer/count vectors carry one extra bit so that a full FIFO can be told apart from an empty one.
  function automatic int unsigned dc_fifo_ptr_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/dc_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for dc_fifo_af_ae: synchronous write, registered read port cleared by reset.
module dc_fifo_mem
  import dc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = dc_fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dc_fifo_af_ae.sv
// Single-clock FIFO with programmable almost-full / almost-empty thresholds.
// Define DC_FIFO_ERR_FLAGS_EN to add sticky Overflow_err_o / Underflow_err_o outputs.
module dc_fifo_af_ae
  import dc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Write_enable_i,
  input  logic                  Read_enable__i,
  input  logic [ADDR_WIDTH-1:0] differenceAF_i,
  input  logic [ADDR_WIDTH-1:0] differenceAE_i,
  input  logic [DATA_WIDTH-1:0] data_input___i,
`ifdef DC_FIFO_ERR_FLAGS_EN
  output logic                  Overflow_err_o,
  output logic                  Underflow_err_o,
`endif
  output logic [DATA_WIDTH-1:0] data_output__o,
  output logic                  Empty_Indica_o,
  output logic                  Full_Indicat_o,
  output logic                  Almost_Full__o,
  output logic                  Almost_Empty_o
);

  localparam int unsigned PTR_W = dc_fifo_ptr_width(ADDR_WIDTH);
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(dc_fifo_depth(ADDR_WIDTH));

  ptr_t     wr_ptr;
  ptr_t     rd_ptr;
  ptr_t     count;
  ptr_t     af_level;
  logic     empty;
  logic     full;
  logic     wr_acc;
  logic     rd_acc;
  fifo_op_e op;

  always_comb begin
    count    = wr_ptr - rd_ptr;
    empty    = (count == '0);
    full     = (count == DEPTH_P);
    // differenceAF_i < DEPTH always, so the subtraction cannot wrap.
    af_level = DEPTH_P - {1'b0, differenceAF_i};
    wr_acc   = Write_enable_i && !full;
    rd_acc   = Read_enable__i && !empty;
    op       = fifo_op_e'({rd_acc, wr_acc});
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      unique case (op)
        OP_WRITE: wr_ptr <= wr_ptr + ptr_t'(1);
        OP_READ:  rd_ptr <= rd_ptr + ptr_t'(1);
        OP_BOTH: begin
          wr_ptr <= wr_ptr + ptr_t'(1);
          rd_ptr <= rd_ptr + ptr_t'(1);
        end
        default: ;
      endcase
    end
  end

  dc_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rstn (rstn),
    .we   (rstn && wr_acc),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(data_input___i),
    .re   (rd_acc),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(data_output__o)
  );

  assign Empty_Indica_o = empty;
  assign Full_Indicat_o = full;
  assign Almost_Full__o = (count >= af_level);
  assign Almost_Empty_o = (count <= {1'b0, differenceAE_i});

`ifdef DC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      Overflow_err_o  <= 1'b0;
      Underflow_err_o <= 1'b0;
    end else begin
      if (Write_enable_i && full) begin
        Overflow_err_o <= 1'b1;
      end
      if (Read_enable__i && empty) begin
        Underflow_err_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dc_fifo_af_ae.sv
// Self-checking bench for dc_fifo_af_ae (DATA_WIDTH=12, ADDR_WIDTH=3) against a queue-based model.
module tb_dc_fifo_af_ae;

  localparam int unsigned DW    = 12;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          we;
  logic          re;
  logic [AW-1:0] daf;
  logic [AW-1:0] dae;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          empty_o;
  logic          full_o;
  logic          af_o;
  logic          ae_o;
`ifdef DC_FIFO_ERR_FLAGS_EN
  logic          ovf_o;
  logic          unf_o;
`endif

  always #5 clk = ~clk;

  dc_fifo_af_ae #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .Write_enable_i(we),
    .Read_enable__i(re),
    .differenceAF_i(daf),
    .differenceAE_i(dae),
    .data_input___i(din),
`ifdef DC_FIFO_ERR_FLAGS_EN
    .Overflow_err_o (ovf_o),
    .Underflow_err_o(unf_o),
`endif
    .data_output__o(dout),
    .Empty_Indica_o(empty_o),
    .Full_Indicat_o(full_o),
    .Almost_Full__o(af_o),
    .Almost_Empty_o(ae_o)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus the last word handed out.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_out;
  bit            m_ovf;
  bit            m_unf;
  bit            m_valid = 1'b0;
  bit            m_full;
  bit            m_empty;

  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      if (we && m_full)  m_ovf = 1'b1;
      if (re && m_empty) m_unf = 1'b1;
      if (re && !m_empty) m_out = q.pop_front();
      if (we && !m_full)  q.push_back(din);
    end
    m_valid = 1'b1;
  end

  int unsigned sz;
  always @(negedge clk) begin
    if (m_valid) begin
      sz = q.size();
      chk("empty", 32'(empty_o), 32'(sz == 0));
      chk("full", 32'(full_o), 32'(sz == DEPTH));
      chk("almost_full", 32'(af_o), 32'(sz >= DEPTH - daf));
      chk("almost_empty", 32'(ae_o), 32'(sz <= dae));
      chk("data_out", 32'(dout), 32'(m_out));
`ifdef DC_FIFO_ERR_FLAGS_EN
      chk("overflow", 32'(ovf_o), 32'(m_ovf));
      chk("underflow", 32'(unf_o), 32'(m_unf));
`endif
    end
  end

  // Inputs change 2 time units after the falling edge; returns just after the following falling edge.
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    rstn = r;
    we   = w;
    re   = rd;
    din  = d;
    @(negedge clk);
    #2;
  endtask

  int unsigned wbias;
  int unsigned rbias;

  initial begin
    rstn = 1'b0;
    we   = 1'b0;
    re   = 1'b0;
    din  = '0;
    daf  = AW'(2);
    dae  = AW'(2);
    @(negedge clk);
    #2;

    // Reset then idle
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_ae", 32'(ae_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_af", 32'(af_o), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);

    // Fill 0x001..0x008, then a dropped write
    for (int unsigned k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, DW'(k));
      chk("fill_ae", 32'(ae_o), 32'(k <= 2));
      chk("fill_af", 32'(af_o), 32'(k >= 6));
      chk("fill_full", 32'(full_o), 32'(k == 8));
    end
    cyc(1'b1, 1'b1, 1'b0, 12'hFFF);
    chk("drop_full", 32'(full_o), 32'd1);
`ifdef DC_FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(ovf_o), 32'd1);
`endif

    // Drain, then read while empty
    for (int unsigned k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 1'b1, '0);
      chk("drain_dout", 32'(dout), k);
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, '0);
    chk("underrun_dout", 32'(dout), 32'h008);
`ifdef DC_FIFO_ERR_FLAGS_EN
    chk("unf_set", 32'(unf_o), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("unf_sticky", 32'(unf_o), 32'd1);
`endif

    // Count of 4 held through simultaneous read/write
    for (int unsigned k = 5; k <= 8; k++) cyc(1'b1, 1'b1, 1'b0, DW'(k));
    for (int unsigned n = 0; n < 10; n++) begin
      cyc(1'b1, 1'b1, 1'b1, DW'(32'h100 + n));
      chk("rw_dout", 32'(dout), (n < 4) ? 32'(5 + n) : 32'(32'h100 + n - 4));
      chk("rw_ae", 32'(ae_o), 32'd0);
      chk("rw_af", 32'(af_o), 32'd0);
    end

    // Mid-operation reset with a write pending
    cyc(1'b1, 1'b1, 1'b0, 12'h0AA);
    cyc(1'b0, 1'b1, 1'b0, 12'h0BB);
    chk("midrst_empty", 32'(empty_o), 32'd1);
    chk("midrst_dout", 32'(dout), 32'd0);
`ifdef DC_FIFO_ERR_FLAGS_EN
    chk("midrst_ovf", 32'(ovf_o), 32'd0);
    chk("midrst_unf", 32'(unf_o), 32'd0);
`endif
    cyc(1'b1, 1'b1, 1'b0, 12'hABC);
    cyc(1'b1, 1'b0, 1'b1, '0);
    chk("post_rst_dout", 32'(dout), 32'hABC);
    chk("post_rst_empty", 32'(empty_o), 32'd1);

    // Randomised traffic with varying thresholds and occasional resets
    wbias = 50;
    rbias = 50;
    for (int unsigned i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        wbias = $urandom_range(10, 90);
        rbias = $urandom_range(10, 90);
        daf   = AW'($urandom_range(0, DEPTH - 1));
        dae   = AW'($urandom_range(0, DEPTH - 1));
      end
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 99) < wbias,
          $urandom_range(0, 99) < rbias,
          DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
